result_tracker: RTL and testbench
=================================

Name: result_tracker

Overview:
- Consumer end of the Execute stage result interface: takes the E-stage write record (write address, Tnew, early write data, ALU result) and carries it through the E/M and M/W pipeline registers.
- Decrements Tnew at each stage boundary and captures load data in M.
- Drives the GRF write port in W.
- Answers forwarding and stall queries from the D and E stages.
- Sits between Execute, the data memory and the GRF in the 5-stage MIPS pipeline.

Parameters:
TW, 5, Tnew field width (matches Execute T output)
AW, 5, register address width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
e_regw_adr  in  5  E-stage write address, 0 = no write
e_tnew  in  5  E-stage Tnew (0 = early data valid, 1 = ALU result, 2 = load)
e_reg_write  in  32  E-stage early write data (imm/PC+8), valid when e_tnew==0
e_alu_res  in  32  E-stage ALU result
e_pc  in  32  E-stage PC
m_dm_rdata  in  32  data memory read data for the instruction currently in M
d_rs, d_rt  in  5  D-stage source addresses
d_tuse_rs, d_tuse_rt  in  2  D-stage Tuse per source
q_rs, q_rt  in  5  E-stage source addresses
stall  out  1  freeze PC and F/D, bubble D/E
d_rs_fwd, d_rt_fwd  out  1  forward hit for D sources
d_rs_data, d_rt_data  out  32  forwarded values for D
e_rs_fwd, e_rt_fwd  out  1  forward hit for E sources
e_rs_data, e_rt_data  out  32  forwarded values for E
m_alu_res  out  32  M-stage ALU result (DM address)
w_we  out  1  GRF write enable
w_adr  out  5  GRF write address
w_data  out  32  GRF write data
w_pc  out  32  PC of the W instruction

Behaviour:
- Two registered records, M and W. Each record holds {adr, tnew, wdata, alu, pc}.
- Reset: all record fields 0. Consequences: w_we=0, stall=0, all fwd outputs 0, all data outputs 0. Reset wins over any same-cycle input.
- Records advance every cycle; there is no stall or enable on M or W. Bubbles arrive as e_regw_adr=0.
- E→M on each clock:
  - M.adr ← e_regw_adr
  - M.tnew ← sat0(e_tnew−1)
  - M.wdata ← e_reg_write if e_tnew==0; e_alu_res if e_tnew==1; otherwise 0
  - M.alu ← e_alu_res
  - M.pc ← e_pc
- M→W on each clock:
  - W.adr ← M.adr
  - W.tnew ← sat0(M.tnew−1)
  - W.wdata ← m_dm_rdata if M.tnew==1, else M.wdata
- Tnew decrement saturates at 0. There is no wrap for any value, including a TW-bit all-ones input.
- W outputs: w_we = (W.adr≠0); w_adr = W.adr; w_data = W.wdata; w_pc = W.pc.
- A producer "matches" source s when its adr==s and s≠0. Register 0 never hits and never stalls.
- D query for source s with Tuse u:
  - Search order: E (live inputs) → M → W; take the first match only.
  - If that match has tnew==0: fwd=1, data = its wdata (E uses e_reg_write).
  - Otherwise fwd=0, data=0. Older producers are never used when a newer match exists.
- Stall = OR over D sources of (newest matching producer has tnew > u).
- E query: same rule over M then W only; D inputs do not affect the E query.
- stall, fwd and data outputs are combinational from the records and current inputs. Zero latency.
- W-to-D forwarding covers same-cycle GRF read-during-write. The GRF needs no internal bypass.

Decomposition:
- Shared package constants: TNEW_EARLY=0, TNEW_ALU=1, TNEW_LOAD=2, and the record field layout.
- One sub-module, fwd_select, instantiated 4 times (D.rs, D.rt, E.rs, E.rt).
  - Inputs: source address, Tuse, up to three producer {adr, tnew, wdata}.
  - Outputs: hit, data, needs_stall.
  - E-stage instances tie the third producer off to adr=0.

Test Plan:
- Reset held 2 cycles with e_regw_adr=5, e_tnew=1 → w_we=0, stall=0, all fwd=0 throughout; first W write occurs 2 cycles after release.
- ALU chain: E {adr=8, tnew=1, alu=0x1234}; next cycle d_rs=8, tuse=1 → stall=0, d_rs_fwd=1, d_rs_data=0x1234 (from M); 2 cycles after E, w_we=1, w_adr=8, w_data=0x1234.
- Load-use: E {adr=9, tnew=2}, d_rs=9, tuse=0 → stall=1. Next cycle M.tnew=1 → stall still 1. Then m_dm_rdata=0xCAFE is captured; W has tnew=0 → d_rs_data=0xCAFE, stall=0.
- Priority: M holds {adr=3, wdata=0x11} and W holds {adr=3, wdata=0x22}; q_rs=3 → e_rs_data=0x11. With E {adr=3, tnew=0, reg_write=0x33} and d_rs=3 → d_rs_data=0x33.
- $0: e_regw_adr=0, tnew=2, d_rs=0, tuse=0 → stall=0, d_rs_fwd=0, w_we=0 when it reaches W.
- Stale shadow: E {adr=4, tnew=2} and M {adr=4, tnew=0}; d_rt=4, tuse=2 → stall=0, d_rt_fwd=0 (M value not used).

Source files
------------

// File: rtl/result_tracker_pkg.sv
// Shared constants, record layout and helpers for the result tracker.
package result_tracker_pkg;

    localparam int unsigned TW = 5;  // Tnew field width
    localparam int unsigned AW = 5;  // register address width

    // Tnew codes as produced by Execute
    localparam logic [TW-1:0] TNEW_EARLY = TW'(0);
    localparam logic [TW-1:0] TNEW_ALU   = TW'(1);
    localparam logic [TW-1:0] TNEW_LOAD  = TW'(2);

    // One in-flight write record
    typedef struct packed {
        logic [AW-1:0] adr;
        logic [TW-1:0] tnew;
        logic [31:0]   wdata;
        logic [31:0]   alu;
        logic [31:0]   pc;
    } rec_t;

    // Tnew decrement that stops at zero
    function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // Write data known at the end of E: early data, ALU result, or nothing yet
    function automatic logic [31:0] e_wdata(input logic [TW-1:0] t,
                                            input logic [31:0]   reg_write,
                                            input logic [31:0]   alu_res);
        if (t == TNEW_EARLY) return reg_write;
        if (t == TNEW_ALU)   return alu_res;
        return '0;
    endfunction

endpackage

// File: rtl/result_tracker_if.sv
// Bundle of E-stage record, memory data, hazard queries and GRF write port.
interface result_tracker_if;
    import result_tracker_pkg::*;

    logic [AW-1:0] e_regw_adr;
    logic [TW-1:0] e_tnew;
    logic [31:0]   e_reg_write;
    logic [31:0]   e_alu_res;
    logic [31:0]   e_pc;
    logic [31:0]   m_dm_rdata;
    logic [AW-1:0] d_rs;
    logic [AW-1:0] d_rt;
    logic [1:0]    d_tuse_rs;
    logic [1:0]    d_tuse_rt;
    logic [AW-1:0] q_rs;
    logic [AW-1:0] q_rt;

    logic          stall;
    logic          d_rs_fwd;
    logic          d_rt_fwd;
    logic [31:0]   d_rs_data;
    logic [31:0]   d_rt_data;
    logic          e_rs_fwd;
    logic          e_rt_fwd;
    logic [31:0]   e_rs_data;
    logic [31:0]   e_rt_data;
    logic [31:0]   m_alu_res;
    logic          w_we;
    logic [AW-1:0] w_adr;
    logic [31:0]   w_data;
    logic [31:0]   w_pc;

    // Pipeline side: drives records and queries, observes answers
    modport master (
        output e_regw_adr, e_tnew, e_reg_write, e_alu_res, e_pc, m_dm_rdata,
               d_rs, d_rt, d_tuse_rs, d_tuse_rt, q_rs, q_rt,
        input  stall, d_rs_fwd, d_rt_fwd, d_rs_data, d_rt_data,
               e_rs_fwd, e_rt_fwd, e_rs_data, e_rt_data,
               m_alu_res, w_we, w_adr, w_data, w_pc
    );

    // Tracker side
    modport slave (
        input  e_regw_adr, e_tnew, e_reg_write, e_alu_res, e_pc, m_dm_rdata,
               d_rs, d_rt, d_tuse_rs, d_tuse_rt, q_rs, q_rt,
        output stall, d_rs_fwd, d_rt_fwd, d_rs_data, d_rt_data,
               e_rs_fwd, e_rt_fwd, e_rs_data, e_rt_data,
               m_alu_res, w_we, w_adr, w_data, w_pc
    );

endinterface

// File: rtl/result_tracker_fwd_select.sv
// Picks the newest producer of a source register and decides forward/stall.
module fwd_select
    import result_tracker_pkg::*;
(
    input  logic [AW-1:0]         src,
    input  logic [1:0]            tuse,
    input  logic [2:0][AW-1:0]    p_adr,    // index 0 is the newest producer
    input  logic [2:0][TW-1:0]    p_tnew,
    input  logic [2:0][31:0]      p_wdata,
    output logic                  hit,
    output logic [31:0]           data,
    output logic                  needs_stall
);

    logic found;

    // First match wins; older producers are shadowed even when not yet ready
    always_comb begin
        hit         = 1'b0;
        data        = '0;
        needs_stall = 1'b0;
        found       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!found && src != '0 && p_adr[i] == src) begin
                found       = 1'b1;
                needs_stall = p_tnew[i] > TW'(tuse);
                if (p_tnew[i] == '0) begin
                    hit  = 1'b1;
                    data = p_wdata[i];
                end
            end
        end
    end

endmodule

// File: rtl/result_tracker.sv
// Carries E-stage write records through M and W, drives the GRF write port
// and answers forwarding/stall queries for D and E.
module result_tracker
    import result_tracker_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    result_tracker_if.slave bus
);

    rec_t m_q, m_d, w_q, w_d;
    logic [31:0] e_prod_wdata;
    logic [31:0] m_prod_wdata;

    // Next M/W records; load data joins the record as it leaves M
    always_comb begin
        m_d.adr   = bus.e_regw_adr;
        m_d.tnew  = tnew_dec(bus.e_tnew);
        m_d.wdata = e_wdata(bus.e_tnew, bus.e_reg_write, bus.e_alu_res);
        m_d.alu   = bus.e_alu_res;
        m_d.pc    = bus.e_pc;

        w_d.adr   = m_q.adr;
        w_d.tnew  = tnew_dec(m_q.tnew);
        w_d.wdata = (m_q.tnew == TNEW_ALU) ? bus.m_dm_rdata : m_q.wdata;
        w_d.alu   = m_q.alu;
        w_d.pc    = m_q.pc;
    end

    // Record registers advance unconditionally every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            m_q <= '0;
            w_q <= '0;
        end else begin
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign e_prod_wdata = bus.e_reg_write;
    assign m_prod_wdata = m_q.wdata;

    logic d_rs_stall, d_rt_stall;

    fwd_select u_d_rs (
        .src         (bus.d_rs),
        .tuse        (bus.d_tuse_rs),
        .p_adr       ({w_q.adr, m_q.adr, bus.e_regw_adr}),
        .p_tnew      ({w_q.tnew, m_q.tnew, bus.e_tnew}),
        .p_wdata     ({w_q.wdata, m_prod_wdata, e_prod_wdata}),
        .hit         (bus.d_rs_fwd),
        .data        (bus.d_rs_data),
        .needs_stall (d_rs_stall)
    );

    fwd_select u_d_rt (
        .src         (bus.d_rt),
        .tuse        (bus.d_tuse_rt),
        .p_adr       ({w_q.adr, m_q.adr, bus.e_regw_adr}),
        .p_tnew      ({w_q.tnew, m_q.tnew, bus.e_tnew}),
        .p_wdata     ({w_q.wdata, m_prod_wdata, e_prod_wdata}),
        .hit         (bus.d_rt_fwd),
        .data        (bus.d_rt_data),
        .needs_stall (d_rt_stall)
    );

    // E-stage queries see only M then W; third slot never matches
    fwd_select u_e_rs (
        .src         (bus.q_rs),
        .tuse        (2'd0),
        .p_adr       ({{AW{1'b0}}, w_q.adr, m_q.adr}),
        .p_tnew      ({{TW{1'b0}}, w_q.tnew, m_q.tnew}),
        .p_wdata     ({32'd0, w_q.wdata, m_prod_wdata}),
        .hit         (bus.e_rs_fwd),
        .data        (bus.e_rs_data),
        .needs_stall ()
    );

    fwd_select u_e_rt (
        .src         (bus.q_rt),
        .tuse        (2'd0),
        .p_adr       ({{AW{1'b0}}, w_q.adr, m_q.adr}),
        .p_tnew      ({{TW{1'b0}}, w_q.tnew, m_q.tnew}),
        .p_wdata     ({32'd0, w_q.wdata, m_prod_wdata}),
        .hit         (bus.e_rt_fwd),
        .data        (bus.e_rt_data),
        .needs_stall ()
    );

    assign bus.stall     = d_rs_stall | d_rt_stall;
    assign bus.m_alu_res = m_q.alu;
    assign bus.w_we      = (w_q.adr != '0);
    assign bus.w_adr     = w_q.adr;
    assign bus.w_data    = w_q.wdata;
    assign bus.w_pc      = w_q.pc;

endmodule

// File: tb/tb_result_tracker.sv
// Randomized and directed checks of result_tracker against a history model.
module tb_result_tracker;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    result_tracker_if bus ();

    result_tracker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  adr;
        logic [4:0]  tnew;
        logic [31:0] rw;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] dm;
        logic [4:0]  drs, drt, qrs, qrt;
        logic [1:0]  trs, trt;
    } in_t;

    // An instruction that left E, plus the memory data seen while it sat in M
    typedef struct {
        logic [4:0]  adr;
        logic [4:0]  tnew0;
        logic [31:0] rw;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] ld;
    } hist_t;

    hist_t m_h, w_h;
    in_t   cur;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic hist_t zero_h();
        hist_t h;
        h.adr = 0; h.tnew0 = 0; h.rw = 0; h.alu = 0; h.pc = 0; h.ld = 0;
        return h;
    endfunction

    function automatic in_t idle_in();
        in_t x;
        x.adr = 0; x.tnew = 0; x.rw = 0; x.alu = 0; x.pc = 0; x.dm = 0;
        x.drs = 0; x.drt = 0; x.qrs = 0; x.qrt = 0; x.trs = 0; x.trt = 0;
        return x;
    endfunction

    // Cycles still to wait after 'age' stage boundaries, never below zero
    function automatic int remaining(input logic [4:0] t0, input int age);
        int r;
        r = int'(t0) - age;
        return (r < 0) ? 0 : r;
    endfunction

    // Value the instruction will write, as known 'age' stages after E
    function automatic logic [31:0] value_at(input hist_t h, input int age);
        if (age >= 2 && h.tnew0 == 5'd2) return h.ld;
        if (h.tnew0 == 5'd0) return h.rw;
        if (h.tnew0 == 5'd1) return h.alu;
        return 32'd0;
    endfunction

    task automatic query(input logic [4:0] s, input logic [1:0] u, input bit use_e,
                         output bit hit, output logic [31:0] d, output bit st);
        hist_t p [3];
        hist_t e;
        hit = 0; d = 0; st = 0;
        e = zero_h();
        e.adr = cur.adr; e.tnew0 = cur.tnew; e.rw = cur.rw; e.alu = cur.alu;
        p[0] = e; p[1] = m_h; p[2] = w_h;
        if (s == 0) return;
        for (int age = use_e ? 0 : 1; age < 3; age++) begin
            if (p[age].adr == s) begin
                st = remaining(p[age].tnew0, age) > int'(u);
                if (remaining(p[age].tnew0, age) == 0) begin
                    hit = 1;
                    d   = (age == 0) ? cur.rw : value_at(p[age], age);
                end
                return;
            end
        end
    endtask

    task automatic compare_all();
        bit h1, h2, h3, h4, s1, s2, s3, s4;
        logic [31:0] d1, d2, d3, d4;
        query(cur.drs, cur.trs, 1'b1, h1, d1, s1);
        query(cur.drt, cur.trt, 1'b1, h2, d2, s2);
        query(cur.qrs, 2'd0,    1'b0, h3, d3, s3);
        query(cur.qrt, 2'd0,    1'b0, h4, d4, s4);
        check("stall",     32'(bus.stall),    32'(s1 | s2));
        check("d_rs_fwd",  32'(bus.d_rs_fwd), 32'(h1));
        check("d_rs_data", bus.d_rs_data,     d1);
        check("d_rt_fwd",  32'(bus.d_rt_fwd), 32'(h2));
        check("d_rt_data", bus.d_rt_data,     d2);
        check("e_rs_fwd",  32'(bus.e_rs_fwd), 32'(h3));
        check("e_rs_data", bus.e_rs_data,     d3);
        check("e_rt_fwd",  32'(bus.e_rt_fwd), 32'(h4));
        check("e_rt_data", bus.e_rt_data,     d4);
        check("m_alu_res", bus.m_alu_res,     m_h.alu);
        check("w_we",      32'(bus.w_we),     32'(w_h.adr != 0));
        check("w_adr",     32'(bus.w_adr),    32'(w_h.adr));
        check("w_data",    bus.w_data,        value_at(w_h, 2));
        check("w_pc",      bus.w_pc,          w_h.pc);
    endtask

    // Drive one cycle's inputs and check outputs on the falling edge
    task automatic apply(input in_t x, input bit rst);
        cur             = x;
        reset           = rst;
        bus.e_regw_adr  = x.adr;
        bus.e_tnew      = x.tnew;
        bus.e_reg_write = x.rw;
        bus.e_alu_res   = x.alu;
        bus.e_pc        = x.pc;
        bus.m_dm_rdata  = x.dm;
        bus.d_rs        = x.drs;
        bus.d_rt        = x.drt;
        bus.d_tuse_rs   = x.trs;
        bus.d_tuse_rt   = x.trt;
        bus.q_rs        = x.qrs;
        bus.q_rt        = x.qrt;
        @(negedge clk);
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_h = zero_h();
            w_h = zero_h();
        end else begin
            w_h    = m_h;
            w_h.ld = cur.dm;
            m_h    = zero_h();
            m_h.adr = cur.adr; m_h.tnew0 = cur.tnew; m_h.rw = cur.rw;
            m_h.alu = cur.alu; m_h.pc = cur.pc;
        end
        #1;
    endtask

    function automatic in_t rand_in();
        in_t x;
        x.adr  = 5'($urandom_range(0, 7));
        x.tnew = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        x.rw   = $urandom; x.alu = $urandom; x.pc = $urandom; x.dm = $urandom;
        x.drs  = 5'($urandom_range(0, 7)); x.drt = 5'($urandom_range(0, 7));
        x.qrs  = 5'($urandom_range(0, 7)); x.qrt = 5'($urandom_range(0, 7));
        x.trs  = 2'($urandom); x.trt = 2'($urandom);
        return x;
    endfunction

    initial begin
        in_t x;
        m_h = zero_h();
        w_h = zero_h();

        // Reset held with a live producer: nothing may leak out
        x = idle_in(); x.adr = 5; x.tnew = 1; x.alu = 32'h55; x.pc = 32'h100;
        x.dm = 32'hdead;
        for (int i = 0; i < 2; i++) begin
            apply(x, 1'b1);
            check("rst_w_we", 32'(bus.w_we), 32'd0);
            check("rst_stall", 32'(bus.stall), 32'd0);
            tick();
        end
        apply(x, 1'b0); tick();
        x = idle_in();
        apply(x, 1'b0);
        check("rel_w_we_early", 32'(bus.w_we), 32'd0);
        tick();
        apply(x, 1'b0);
        check("rel_w_we", 32'(bus.w_we), 32'd1);
        check("rel_w_data", bus.w_data, 32'h55);
        tick();

        // ALU chain forwarded from M, then written from W
        x = idle_in(); x.adr = 8; x.tnew = 1; x.alu = 32'h1234;
        apply(x, 1'b0); tick();
        x = idle_in(); x.drs = 8; x.trs = 1;
        apply(x, 1'b0);
        check("alu_fwd", 32'(bus.d_rs_fwd), 32'd1);
        check("alu_data", bus.d_rs_data, 32'h1234);
        check("alu_stall", 32'(bus.stall), 32'd0);
        tick();
        x = idle_in();
        apply(x, 1'b0);
        check("alu_w_adr", 32'(bus.w_adr), 32'd8);
        check("alu_w_data", bus.w_data, 32'h1234);
        tick();

        // Load-use: stall twice, then forward captured memory data from W
        x = idle_in(); x.adr = 9; x.tnew = 2; x.drs = 9;
        apply(x, 1'b0);
        check("ld_stall0", 32'(bus.stall), 32'd1);
        tick();
        x = idle_in(); x.drs = 9; x.dm = 32'hcafe;
        apply(x, 1'b0);
        check("ld_stall1", 32'(bus.stall), 32'd1);
        tick();
        x = idle_in(); x.drs = 9;
        apply(x, 1'b0);
        check("ld_stall2", 32'(bus.stall), 32'd0);
        check("ld_data", bus.d_rs_data, 32'hcafe);
        tick();

        // Newest producer wins
        x = idle_in(); x.adr = 3; x.rw = 32'h22;
        apply(x, 1'b0); tick();
        x = idle_in(); x.adr = 3; x.rw = 32'h11;
        apply(x, 1'b0); tick();
        x = idle_in(); x.adr = 3; x.rw = 32'h33; x.qrs = 3; x.drs = 3;
        apply(x, 1'b0);
        check("prio_e", bus.e_rs_data, 32'h11);
        check("prio_d", bus.d_rs_data, 32'h33);
        tick();

        // Register 0 never hits, stalls or writes
        x = idle_in(); x.tnew = 2;
        apply(x, 1'b0);
        check("r0_stall", 32'(bus.stall), 32'd0);
        check("r0_fwd", 32'(bus.d_rs_fwd), 32'd0);
        tick();
        x = idle_in();
        apply(x, 1'b0); tick();
        apply(x, 1'b0);
        check("r0_w_we", 32'(bus.w_we), 32'd0);
        tick();

        // Unready newer producer shadows a ready older one
        x = idle_in(); x.adr = 4; x.rw = 32'h44;
        apply(x, 1'b0); tick();
        x = idle_in(); x.adr = 4; x.tnew = 2; x.drt = 4; x.trt = 2;
        apply(x, 1'b0);
        check("shadow_stall", 32'(bus.stall), 32'd0);
        check("shadow_fwd", 32'(bus.d_rt_fwd), 32'd0);
        tick();

        // Random traffic with occasional mid-run reset
        for (int i = 0; i < 400; i++) begin
            apply(rand_in(), ($urandom_range(0, 49) == 0));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
